// File: rtl/scrambler_frame_feeder.sv
// Sample FIFO plus framing FSM feeding the scrambler with gap-free FRAME_LEN-sample bursts,
// each carrying a per-frame shift key taken from a Galois LFSR.
module scrambler_frame_feeder #(
  parameter int unsigned FRAME_LEN  = 128,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned KEY_W      = 24,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter logic [KEY_W-1:0] LFSR_SEED = 24'hA5A5A5,
  parameter logic [KEY_W-1:0] LFSR_TAPS = 24'hE10000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              bypass,
  output logic              di_en,
  output logic [DATA_W-1:0] out_real,
  output logic [KEY_W-1:0]  shift_key,
  output logic              frame_start,
  output logic [15:0]       frame_count,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [IW-1:0]     idx;
  logic [KEY_W-1:0]  lfsr;
  state_t            state;

  logic full, rd, wr, start;

  assign full = (count == CW'(FIFO_DEPTH));

  // At the last sample of a frame the continue decision counts this cycle's incoming
  // sample, so a steady stream chains frames back-to-back without a bubble.
  always_comb begin
    start = 1'b0;
    rd    = 1'b0;
    case (state)
      IDLE: begin
        start = (32'(count) >= FRAME_LEN);
        rd    = start;
      end
      STREAM: begin
        if (idx == LAST_IDX) begin
          start = ((32'(count) + 32'(in_valid)) >= FRAME_LEN);
          rd    = start;
        end else begin
          rd = 1'b1;
        end
      end
      default: begin
        start = 1'b0;
        rd    = 1'b0;
      end
    endcase
    wr = in_valid && (!full || rd);
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= in_sample;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      idx         <= '0;
      lfsr        <= LFSR_SEED;
      state       <= IDLE;
      di_en       <= 1'b0;
      out_real    <= '0;
      shift_key   <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) begin
        rd_ptr   <= rd_ptr + AW'(1);
        out_real <= mem[rd_ptr];
      end
      count       <= count + CW'(wr) - CW'(rd);
      if (in_valid && !wr) overflow <= 1'b1;
      di_en       <= rd;
      frame_start <= start;
      if (start) begin
        shift_key   <= bypass ? '0 : lfsr;
        lfsr        <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        frame_count <= frame_count + 16'd1;
        idx         <= '0;
        state       <= STREAM;
      end else if (state == STREAM) begin
        if (idx == LAST_IDX) state <= IDLE;
        else                 idx   <= idx + IW'(1);
      end
    end
  end

endmodule
